// File: rtl/universal_shift_reg.sv
// universal_shift_reg
//   A WIDTH-bit register bank with hold, parallel load, logical shift, rotate,
//   clear and invert modes. It also keeps a saturating count of the
//   shift/rotate operations performed since the last load, clear or reset.
//
// Ports
//   clk_signal      : clock. All state updates happen on the rising edge.
//   reset_signal    : synchronous, active-low reset. It overrides the enable
//                     and the mode.
//   enable_signal   : 1 = execute mode_select on this edge, 0 = hold.
//   mode_select     : operation code (HOLD/LOAD/SHL/SHR/ROL/ROR/CLR/INV).
//   d_input         : parallel load data.
//   serial_left_in  : bit that enters the LSB on a shift-left.
//   serial_right_in : bit that enters the MSB on a shift-right.
//   q_output        : register contents.
//   qb_output       : bitwise complement of q_output.
//   serial_msb_out  : q_output[WIDTH-1].
//   serial_lsb_out  : q_output[0].
//   shift_count     : shifts/rotates since the last load/clear, saturating.
//   count_sat       : 1 when shift_count is all ones.
module universal_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk_signal,
  input  logic                 reset_signal,
  input  logic                 enable_signal,
  input  logic [2:0]           mode_select,
  input  logic [WIDTH-1:0]     d_input,
  input  logic                 serial_left_in,
  input  logic                 serial_right_in,
  output logic [WIDTH-1:0]     q_output,
  output logic [WIDTH-1:0]     qb_output,
  output logic                 serial_msb_out,
  output logic                 serial_lsb_out,
  output logic [CNT_WIDTH-1:0] shift_count,
  output logic                 count_sat
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_INV  = 3'b111
  } mode_t;

  logic [WIDTH-1:0]     q_reg;
  logic [WIDTH-1:0]     q_next;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 cnt_bump;
  logic                 cnt_zero;
  mode_t                mode;

  assign mode = mode_t'(mode_select);

  always_comb begin
    q_next   = q_reg;
    cnt_bump = 1'b0;
    cnt_zero = 1'b0;
    case (mode)
      MODE_HOLD: q_next = q_reg;
      MODE_LOAD: begin
        q_next   = d_input;
        cnt_zero = 1'b1;
      end
      MODE_SHL: begin
        q_next   = {q_reg[WIDTH-2:0], serial_left_in};
        cnt_bump = 1'b1;
      end
      MODE_SHR: begin
        q_next   = {serial_right_in, q_reg[WIDTH-1:1]};
        cnt_bump = 1'b1;
      end
      MODE_ROL: begin
        q_next   = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        cnt_bump = 1'b1;
      end
      MODE_ROR: begin
        q_next   = {q_reg[0], q_reg[WIDTH-1:1]};
        cnt_bump = 1'b1;
      end
      MODE_CLR: begin
        q_next   = '0;
        cnt_zero = 1'b1;
      end
      MODE_INV: q_next = ~q_reg;
      default:  q_next = q_reg;
    endcase
  end

  // The counter sticks at all ones once it has saturated. Only a load, a
  // clear or a reset brings it back to zero.
  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_zero)
      cnt_next = '0;
    else if (cnt_bump && (cnt_reg != {CNT_WIDTH{1'b1}}))
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk_signal) begin
    if (!reset_signal) begin
      q_reg   <= '0;
      cnt_reg <= '0;
    end else if (enable_signal) begin
      q_reg   <= q_next;
      cnt_reg <= cnt_next;
    end
  end

  assign q_output       = q_reg;
  assign qb_output      = ~q_reg;
  assign serial_msb_out = q_reg[WIDTH-1];
  assign serial_lsb_out = q_reg[0];
  assign shift_count    = cnt_reg;
  assign count_sat      = &cnt_reg;

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 4;
  localparam int unsigned MODV = 1 << WIDTH;
  localparam int unsigned HALF = MODV / 2;
  localparam int unsigned CMAX = (1 << CNT_WIDTH) - 1;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROL = 3'd4, ROR = 3'd5, CLR = 3'd6, INV = 3'd7;

  logic                 clk_signal = 1'b0;
  logic                 reset_signal = 1'b0;
  logic                 enable_signal = 1'b0;
  logic [2:0]           mode_select = 3'd0;
  logic [WIDTH-1:0]     d_input = '0;
  logic                 serial_left_in = 1'b0;
  logic                 serial_right_in = 1'b0;
  logic [WIDTH-1:0]     q_output;
  logic [WIDTH-1:0]     qb_output;
  logic                 serial_msb_out;
  logic                 serial_lsb_out;
  logic [CNT_WIDTH-1:0] shift_count;
  logic                 count_sat;

  universal_shift_reg #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_signal      (clk_signal),
    .reset_signal    (reset_signal),
    .enable_signal   (enable_signal),
    .mode_select     (mode_select),
    .d_input         (d_input),
    .serial_left_in  (serial_left_in),
    .serial_right_in (serial_right_in),
    .q_output        (q_output),
    .qb_output       (qb_output),
    .serial_msb_out  (serial_msb_out),
    .serial_lsb_out  (serial_lsb_out),
    .shift_count     (shift_count),
    .count_sat       (count_sat)
  );

  always #5 clk_signal = ~clk_signal;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: register value and count held as plain integers.
  int unsigned m_q   = 0;
  int unsigned m_cnt = 0;
  bit          m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int unsigned bump(input int unsigned c);
    return (c < CMAX) ? c + 1 : CMAX;
  endfunction

  task automatic cyc(input bit rst_n, input bit en, input logic [2:0] mode,
                     input logic [WIDTH-1:0] d, input bit sli, input bit sri);
    reset_signal    = rst_n;
    enable_signal   = en;
    mode_select     = mode;
    d_input         = d;
    serial_left_in  = sli;
    serial_right_in = sri;
    if (m_valid) begin
      check("msb_pre", serial_msb_out, m_q / HALF);
      check("lsb_pre", serial_lsb_out, m_q % 2);
    end
    @(posedge clk_signal);
    if (!rst_n) begin
      m_q = 0;
      m_cnt = 0;
    end else if (en) begin
      case (mode)
        LOAD: begin m_q = d; m_cnt = 0; end
        SHL:  begin m_q = (m_q * 2) % MODV + sli; m_cnt = bump(m_cnt); end
        SHR:  begin m_q = m_q / 2 + sri * HALF; m_cnt = bump(m_cnt); end
        ROL:  begin m_q = (m_q * 2) % MODV + m_q / HALF; m_cnt = bump(m_cnt); end
        ROR:  begin m_q = m_q / 2 + (m_q % 2) * HALF; m_cnt = bump(m_cnt); end
        CLR:  begin m_q = 0; m_cnt = 0; end
        INV:  m_q = (MODV - 1) - m_q;
        default: ;
      endcase
    end
    m_valid = 1'b1;
    #1;
    check("q", q_output, m_q);
    check("qb", qb_output, (MODV - 1) - m_q);
    check("msb", serial_msb_out, m_q / HALF);
    check("lsb", serial_lsb_out, m_q % 2);
    check("cnt", shift_count, m_cnt);
    check("sat", count_sat, (m_cnt == CMAX) ? 1 : 0);
  endtask

  initial begin
    @(negedge clk_signal);
    // reset overrides an enabled load of all ones
    cyc(0, 1, LOAD, 8'hFF, 0, 0);
    check("rst_q", q_output, 8'h00);
    check("rst_qb", qb_output, 8'hFF);
    check("rst_cnt", shift_count, 0);
    cyc(1, 1, LOAD, 8'hA5, 0, 0);
    check("load_a5", q_output, 8'hA5);
    check("load_qb", qb_output, 8'h5A);
    cyc(1, 1, SHL, 8'h00, 1, 0);
    check("shl_4b", q_output, 8'h4B);
    check("shl_cnt", shift_count, 1);
    cyc(1, 1, SHR, 8'h00, 0, 0);
    check("shr_25", q_output, 8'h25);
    check("shr_cnt", shift_count, 2);
    // rotates
    cyc(1, 1, LOAD, 8'h81, 0, 0);
    cyc(1, 1, ROL, 8'h00, 0, 0);
    check("rol_03", q_output, 8'h03);
    cyc(1, 1, ROR, 8'h00, 1, 1);
    check("ror_81", q_output, 8'h81);
    cyc(1, 1, LOAD, 8'h81, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, ROL, 8'h00, 1, 1);
    check("rol8_q", q_output, 8'h81);
    check("rol8_cnt", shift_count, 8);
    // enable low and HOLD, with a non-zero count
    cyc(1, 1, LOAD, 8'h3C, 0, 0);
    cyc(1, 1, ROL, 8'h00, 0, 0);
    cyc(1, 1, ROR, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, SHL, 8'hFF, 1, 1);
    check("dis_q", q_output, 8'h3C);
    check("dis_cnt", shift_count, 2);
    cyc(1, 1, HOLD, 8'hFF, 1, 1);
    check("hold_q", q_output, 8'h3C);
    check("hold_cnt", shift_count, 2);
    // saturation
    for (int i = 0; i < 20; i++) cyc(1, 1, SHL, 8'h00, i[0], 0);
    check("sat_cnt", shift_count, 15);
    check("sat_flag", count_sat, 1);
    cyc(1, 1, LOAD, 8'h00, 0, 0);
    check("unsat_cnt", shift_count, 0);
    check("unsat_flag", count_sat, 0);
    // invert and clear
    cyc(1, 1, LOAD, 8'h0F, 0, 0);
    cyc(1, 1, ROL, 8'h00, 0, 0);
    cyc(1, 1, ROR, 8'h00, 0, 0);
    cyc(1, 1, INV, 8'h00, 0, 0);
    check("inv_q", q_output, 8'hF0);
    check("inv_qb", qb_output, 8'h0F);
    check("inv_cnt", shift_count, 2);
    cyc(1, 1, CLR, 8'hFF, 1, 1);
    check("clr_q", q_output, 8'h00);
    check("clr_cnt", shift_count, 0);
    // reset in the middle of a shift sequence
    cyc(1, 1, LOAD, 8'h5A, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, SHL, 8'h00, 1, 0);
    check("mid_cnt5", shift_count, 5);
    cyc(0, 1, SHL, 8'h00, 1, 0);
    check("mid_rst_q", q_output, 8'h00);
    check("mid_rst_cnt", shift_count, 0);
    cyc(1, 1, SHL, 8'h00, 1, 0);
    check("mid_after_cnt", shift_count, 1);
    check("mid_after_q", q_output, 8'h01);
    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
          3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register bank with hold, parallel load, logical shift, rotate, clear and invert modes.
- Provides both true (q_output) and complemented (qb_output) outputs.
- Keeps a saturating count of shift/rotate operations performed since the last load or clear.
- Used as the general storage/serialiser element in datapath and serial-link labs.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_WIDTH, 4, width of shift_count; counter saturates at 2^CNT_WIDTH-1.

Ports:
- clk_signal  input  1  clock; all state updates on rising edge.
- reset_signal  input  1  synchronous, active-low reset.
- enable_signal  input  1  1 = execute mode_select this cycle; 0 = hold everything.
- mode_select  input  3  operation code (see Behaviour).
- d_input  input  WIDTH  parallel load data.
- serial_left_in  input  1  bit entering LSB on shift-left.
- serial_right_in  input  1  bit entering MSB on shift-right.
- q_output  output  WIDTH  register contents.
- qb_output  output  WIDTH  bitwise complement of q_output.
- serial_msb_out  output  1  q_output[WIDTH-1] (combinational from register).
- serial_lsb_out  output  1  q_output[0] (combinational from register).
- shift_count  output  CNT_WIDTH  shifts/rotates since last load/clear, saturating.
- count_sat  output  1  1 when shift_count is all ones.

Behaviour:
- Reset:
  - Sampled on the rising edge when reset_signal=0.
  - Results: q_output=0, qb_output=all ones, shift_count=0, count_sat=0.
  - Reset overrides enable_signal and mode_select.
- Release: reset_signal going 1 takes effect on the next edge. No state change occurs until an edge with enable_signal=1.
- Enable: with enable_signal=0, the register and counter hold. Inputs are ignored.
- mode_select, applied on the rising edge when enable_signal=1:
  - 000 HOLD: q unchanged; count unchanged.
  - 001 LOAD: q <= d_input; count <= 0.
  - 010 SHL: q <= {q[WIDTH-2:0], serial_left_in}; count +1.
  - 011 SHR: q <= {serial_right_in, q[WIDTH-1:1]}; count +1.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; count +1.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}; count +1.
  - 110 CLR: q <= 0; count <= 0.
  - 111 INV: q <= ~q; count unchanged.
- Latency: one cycle. The result is visible on q_output/qb_output immediately after the edge.
- Output invariant: qb_output == ~q_output at all times, including across reset.
- serial_msb_out and serial_lsb_out reflect the current registered q (pre-edge value for the operation in progress).
- Counter:
  - Increments only on SHL/SHR/ROL/ROR.
  - Saturates at 2^CNT_WIDTH-1; further shifts leave it there with count_sat=1.
  - Only LOAD, CLR or reset return it to 0.
- Unknown inputs: X on d_input is only captured when LOAD is executed. X on mode_select with enable_signal=0 has no effect.
- Reset mid-sequence: a shift sequence interrupted by reset resumes from q=0, count=0. No partial state is retained.

Test Plan (WIDTH=8, CNT_WIDTH=4):
- Reset, then release:
  - reset_signal=0 for 1 edge, with d_input=8'hFF, mode=LOAD, enable=1 -> q=8'h00, qb=8'hFF, shift_count=0.
  - Release -> LOAD 8'hA5 gives q=8'hA5, qb=8'h5A.
- Shifts:
  - q=8'hA5; SHL with serial_left_in=1 -> q=8'h4B, count=1.
  - Then SHR with serial_right_in=0 -> q=8'h25, count=2.
  - serial_msb_out tracks bit 7 after each edge.
- Rotates:
  - LOAD 8'h81, ROL -> 8'h03; ROR -> 8'h81.
  - 8 consecutive ROL -> 8'h81 with count=8.
- Enable/hold:
  - q=8'h3C, enable_signal=0 with mode=SHL for 3 edges -> q stays 8'h3C and count unchanged.
  - mode=HOLD with enable=1 -> same result.
- Saturation:
  - 20 consecutive SHL -> shift_count stops at 15 and count_sat=1.
  - LOAD 8'h00 -> count=0, count_sat=0.
- INV/CLR and mid-op reset:
  - q=8'h0F, INV -> 8'hF0, qb=8'h0F; CLR -> q=0, count=0.
  - During a SHL sequence at count=5, assert reset_signal=0 for one edge -> q=0, count=0; the next SHL gives count=1.
